debug_run_ctrl: RTL and testbench
=================================

DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and breakpoint address width.
REQ-002 SHALL have parameter CNT_W, default 16: step-count width.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1: command strobe.
REQ-006 SHALL have port cmd_ready  output  1: tied 1; every command presented is accepted.
REQ-007 SHALL have port cmd_op  input  2: command code; 00 HALT, 01 RUN, 10 STEP, 11 reserved (no-op).
REQ-008 SHALL have port cmd_count  input  CNT_W: instruction count for STEP.
REQ-009 SHALL have port bp_wr  input  1: breakpoint register write strobe.
REQ-010 SHALL have port bp_wr_en  input  1: breakpoint enable value written on bp_wr.
REQ-011 SHALL have port bp_wr_addr  input  XLEN: breakpoint PC value written on bp_wr.
REQ-012 SHALL have port pc_current  input  XLEN: core's current PC.
REQ-013 SHALL have port core_en  output  1: core may retire one instruction at this edge (gates PC, register-file and data-memory writes).
REQ-014 SHALL have port halted  output  1: high in state HALTED.
REQ-015 SHALL have port halt_cause  output  2: 00 reset, 01 HALT command, 10 step done, 11 breakpoint.
REQ-016 SHALL have port cmd_err  output  1: one-cycle pulse when a command is dropped.
REQ-017 SHALL have port instr_count  output  32: retired-instruction count.

Function
REQ-018 SHALL implement states HALTED, RUNNING, STEPPING; core_en SHALL be 0 in HALTED.
REQ-019 SHALL define bp_hit = bp_en & (pc_current == bp_addr) & ~resume, where resume is a flag set on entry to RUNNING/STEPPING and cleared after the first cycle there.
REQ-020 In RUNNING/STEPPING, core_en SHALL equal ~bp_hit, combinationally.
REQ-021 On bp_hit, next state SHALL be HALTED with halt_cause 11; the instruction at bp_addr is not retired.
REQ-022 RUN accepted in HALTED SHALL enter RUNNING at that edge; core_en rises in the following cycle.
REQ-023 STEP accepted in HALTED SHALL load steps_left = cmd_count (0 treated as 1) and enter STEPPING.
REQ-024 In STEPPING, each core_en cycle SHALL decrement steps_left; retiring with steps_left == 1 SHALL enter HALTED, cause 10.
REQ-025 HALT SHALL be accepted in any state: RUNNING/STEPPING go to HALTED, cause 01; in HALTED, cause is unchanged.
REQ-026 RUN or STEP received outside HALTED SHALL be dropped, with state unchanged and cmd_err pulsed next cycle.
REQ-027 When HALT and bp_hit occur in the same cycle, the outcome SHALL be HALTED with cause 11.
REQ-028 In the cycle a command is accepted, core_en SHALL reflect the pre-command state.
REQ-029 bp_wr SHALL update bp_en/bp_addr in any state; the new values are effective the next cycle.
REQ-030 instr_count SHALL increment on every edge with core_en == 1 and wrap from FFFFFFFF to 0.

Reset
REQ-031 Reset SHALL force state HALTED, core_en 0, halted 1, halt_cause 00, cmd_err 0, instr_count 0, steps_left 0, bp_en 0, bp_addr 0, resume 0.
REQ-032 Reset asserted mid-RUN/STEP SHALL drop core_en in the same cycle, asynchronously; a pending step count SHALL be discarded.
REQ-033 After reset release, the block SHALL remain HALTED until a RUN or STEP command arrives.

Structure
REQ-034 State encoding, cmd_op codes and halt_cause codes SHALL live in a shared package dbg_pkg.
REQ-035 SHALL be a single module with no sub-modules; the comparator and counters are inline.

Verification
REQ-036 Reset mid-RUN with instr_count = 5 -> core_en 0 immediately; halted 1, cause 00, instr_count 0.
REQ-037 STEP, count 3, from HALTED, pc = 0 -> core_en high exactly 3 cycles; then halted 1, cause 10, instr_count 3.
REQ-038 bp = 0x34 enabled, RUN from pc = 0 -> halt with pc = 0x34 unretired, cause 11; a second RUN retires 0x34 in its first cycle and continues.
REQ-039 STEP, count 0 -> exactly one core_en cycle, then cause 10.
REQ-040 RUN while RUNNING -> one-cycle cmd_err pulse, state RUNNING; HALT coincident with bp_hit -> cause 11.
REQ-041 CNT_W = 16, STEP 0xFFFF -> 65535 core_en cycles; HALT at cycle 100 -> cause 01, instr_count 100.

Source files
------------

// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------------------
// dbg_pkg -- shared encodings for the debug run controller.
//   state_t      : controller states (HALTED / RUNNING / STEPPING)
//   cmd_op_t     : debugger command codes carried on cmd_op
//   halt_cause_t : reason the core last entered HALTED
// ---------------------------------------------------------------------------
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STEPPING = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_HALT = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'b00,
    CAUSE_HALT  = 2'b01,
    CAUSE_STEP  = 2'b10,
    CAUSE_BP    = 2'b11
  } halt_cause_t;

endpackage

// File: rtl/debug_run_ctrl.sv
// ---------------------------------------------------------------------------
// debug_run_ctrl -- run/halt/single-step controller for a simple core, with
// one PC breakpoint and a retired-instruction counter.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake (ready is always 1)
//   cmd_op, cmd_count : command code (HALT/RUN/STEP/reserved), STEP count
//   bp_wr, bp_wr_en,
//   bp_wr_addr        : breakpoint register write port
//   pc_current        : PC of the instruction the core would retire now
//   core_en           : core may retire one instruction at this edge
//   halted            : controller is in HALTED
//   halt_cause        : why it halted (reset / HALT / step done / breakpoint)
//   cmd_err           : one-cycle pulse after a RUN/STEP was dropped
//   instr_count       : retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module debug_run_ctrl
  import dbg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             bp_wr,
  input  logic             bp_wr_en,
  input  logic [XLEN-1:0]  bp_wr_addr,
  input  logic [XLEN-1:0]  pc_current,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic             cmd_err,
  output logic [31:0]      instr_count
);

  state_t            state;
  halt_cause_t       cause;
  logic              resume;
  logic [CNT_W-1:0]  steps_left;
  logic              bp_en;
  logic [XLEN-1:0]   bp_addr;

  logic              active;
  logic              bp_hit;
  logic              go_cmd;
  logic              halt_cmd;

  assign cmd_ready  = 1'b1;
  assign active     = (state != ST_HALTED);
  // resume masks the breakpoint for the first cycle after a RUN/STEP so the
  // core can step off the instruction it last stopped on.
  assign bp_hit     = bp_en & (pc_current == bp_addr) & ~resume;
  // Combinational so a breakpoint blocks retirement in the same cycle; the
  // state register is asynchronously reset, so core_en drops with reset.
  assign core_en    = active & ~bp_hit;
  assign halted     = (state == ST_HALTED);
  assign halt_cause = cause;

  assign go_cmd   = cmd_valid & ((cmd_op == OP_RUN) | (cmd_op == OP_STEP));
  assign halt_cmd = cmd_valid & (cmd_op == OP_HALT);

  // Controller state, breakpoint register, step and retirement counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_HALTED;
      cause       <= CAUSE_RESET;
      resume      <= 1'b0;
      steps_left  <= '0;
      bp_en       <= 1'b0;
      bp_addr     <= '0;
      cmd_err     <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      if (bp_wr) begin
        bp_en   <= bp_wr_en;
        bp_addr <= bp_wr_addr;
      end

      // RUN/STEP are only meaningful from HALTED; elsewhere they are dropped.
      cmd_err <= go_cmd & active;
      resume  <= 1'b0;

      if (core_en) begin
        instr_count <= instr_count + 32'd1;
      end

      case (state)
        ST_HALTED: begin
          if (cmd_valid && (cmd_op == OP_RUN)) begin
            state  <= ST_RUNNING;
            resume <= 1'b1;
          end else if (cmd_valid && (cmd_op == OP_STEP)) begin
            state      <= ST_STEPPING;
            resume     <= 1'b1;
            steps_left <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
          end else begin
            state <= ST_HALTED;
          end
        end
        ST_RUNNING, ST_STEPPING: begin
          // Breakpoint outranks a coincident HALT command.
          if (bp_hit) begin
            state <= ST_HALTED;
            cause <= CAUSE_BP;
          end else if (halt_cmd) begin
            state <= ST_HALTED;
            cause <= CAUSE_HALT;
          end else if (state == ST_STEPPING) begin
            // No bp_hit here, so core_en is 1 and an instruction retires.
            steps_left <= steps_left - CNT_W'(1);
            if (steps_left == CNT_W'(1)) begin
              state <= ST_HALTED;
              cause <= CAUSE_STEP;
            end else begin
              state <= ST_STEPPING;
            end
          end else begin
            state <= ST_RUNNING;
          end
        end
        default: begin
          state <= ST_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_run_ctrl.sv
module tb_debug_run_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             bp_wr;
  logic             bp_wr_en;
  logic [XLEN-1:0]  bp_wr_addr;
  logic [XLEN-1:0]  pc;
  logic             core_en;
  logic             halted;
  logic [1:0]       halt_cause;
  logic             cmd_err;
  logic [31:0]      instr_count;

  debug_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .bp_wr(bp_wr), .bp_wr_en(bp_wr_en), .bp_wr_addr(bp_wr_addr),
    .pc_current(pc), .core_en(core_en), .halted(halted), .halt_cause(halt_cause),
    .cmd_err(cmd_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ce_seen = 0;

  // Reference model: mode 0 = halted, 1 = running, 2 = stepping.
  int          m_mode;
  bit          m_first;   // first cycle after a RUN/STEP was taken
  logic [1:0]  m_cause;
  logic [31:0] m_cnt;
  int          m_steps;
  bit          m_bpen;
  logic [31:0] m_bpa;
  bit          m_err;

  task automatic model_reset();
    m_mode = 0; m_first = 0; m_cause = 2'd0; m_cnt = 32'd0;
    m_steps = 0; m_bpen = 0; m_bpa = 32'd0; m_err = 0;
  endtask

  function automatic bit m_hit();
    return (m_mode != 0) && m_bpen && (pc == m_bpa) && !m_first;
  endfunction

  function automatic bit m_ce();
    return (m_mode != 0) && !m_hit();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("cmd_ready",   32'(cmd_ready),   32'd1);
    check("core_en",     32'(core_en),     32'(m_ce()));
    check("halted",      32'(halted),      32'(m_mode == 0));
    check("halt_cause",  32'(halt_cause),  32'(m_cause));
    check("cmd_err",     32'(cmd_err),     32'(m_err));
    check("instr_count", instr_count,      m_cnt);
  endtask

  // One clock cycle: compare, predict the edge, advance, update the core PC.
  task automatic tick();
    automatic bit ce, hit, go;
    automatic int n_mode, n_steps;
    automatic bit n_first, n_err, n_bpen;
    automatic logic [1:0] n_cause;
    automatic logic [31:0] n_bpa;
    #2;
    compare_all();
    if (core_en) ce_seen++;
    ce = m_ce(); hit = m_hit();
    go = cmd_valid && (cmd_op == 2'd1 || cmd_op == 2'd2);
    n_mode = m_mode; n_steps = m_steps; n_cause = m_cause;
    n_first = 0; n_err = go && (m_mode != 0);
    n_bpen = bp_wr ? bp_wr_en : m_bpen;
    n_bpa  = bp_wr ? bp_wr_addr : m_bpa;
    if (m_mode == 0) begin
      if (cmd_valid && cmd_op == 2'd1) begin n_mode = 1; n_first = 1; end
      else if (cmd_valid && cmd_op == 2'd2) begin
        n_mode = 2; n_first = 1; n_steps = (cmd_count == 0) ? 1 : int'(cmd_count);
      end
    end else if (hit) begin
      n_mode = 0; n_cause = 2'd3;
    end else if (cmd_valid && cmd_op == 2'd0) begin
      n_mode = 0; n_cause = 2'd1;
    end else if (m_mode == 2) begin
      if (m_steps == 1) begin n_mode = 0; n_cause = 2'd2; end
      n_steps = m_steps - 1;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      m_mode = n_mode; m_steps = n_steps; m_cause = n_cause; m_first = n_first;
      m_err = n_err; m_bpen = n_bpen; m_bpa = n_bpa;
      if (ce) m_cnt = m_cnt + 32'd1;
    end
    if (ce && !reset) pc = pc + 32'd4;
    cmd_valid = 1'b0;
    bp_wr = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = '0;
    bp_wr = 1'b0; bp_wr_en = 1'b0; bp_wr_addr = '0; pc = 32'd0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Reset state, idle, reserved op and HALT while halted are no-ops.
    repeat (3) tick();
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cause",  32'(halt_cause), 32'd0);
    cmd(2'd3, 16'd0);
    cmd(2'd0, 16'd0);
    tick();
    check("rsvd_noerr", 32'(cmd_err), 32'd0);

    // STEP 3 from pc 0.
    pc = 32'd0; ce_seen = 0;
    cmd(2'd2, 16'd3);
    repeat (6) tick();
    check("step3_ce",    ce_seen, 32'd3);
    check("step3_cause", 32'(halt_cause), 32'd2);
    check("step3_cnt",   instr_count, 32'd3);

    // STEP 0 behaves as STEP 1.
    ce_seen = 0;
    cmd(2'd2, 16'd0);
    repeat (4) tick();
    check("step0_ce",    ce_seen, 32'd1);
    check("step0_cause", 32'(halt_cause), 32'd2);

    // Breakpoint at 0x34, RUN from 0.
    do_reset();
    pc = 32'd0;
    bp_wr = 1'b1; bp_wr_en = 1'b1; bp_wr_addr = 32'h34;
    tick();
    cmd(2'd1, 16'd0);
    k = 0;
    while (!halted && k < 100) begin tick(); k++; end
    check("bp_timeout", 32'(k < 100), 32'd1);
    check("bp_pc",      pc, 32'h34);
    check("bp_cause",   32'(halt_cause), 32'd3);
    check("bp_cnt",     instr_count, 32'd13);
    // Second RUN retires 0x34 first and keeps going.
    cmd(2'd1, 16'd0);
    repeat (3) tick();
    check("resume_pc", pc, 32'h40);
    check("resume_cnt", instr_count, 32'd16);

    // RUN / STEP while running are dropped with a cmd_err pulse.
    cmd(2'd1, 16'd0);
    check("err_pulse", 32'(cmd_err), 32'd1);
    tick();
    check("err_clear", 32'(cmd_err), 32'd0);
    check("err_state", 32'(halted), 32'd0);
    cmd(2'd2, 16'd5);
    tick();

    // HALT coincident with a breakpoint hit: breakpoint wins.
    bp_wr = 1'b1; bp_wr_en = 1'b1; bp_wr_addr = pc + 32'd16;
    tick();
    k = 0;
    while (pc != m_bpa && k < 20) begin tick(); k++; end
    check("bp2_timeout", 32'(k < 20), 32'd1);
    cmd(2'd0, 16'd0);
    check("halt_bp_cause", 32'(halt_cause), 32'd3);
    check("halt_bp_halted", 32'(halted), 32'd1);
    tick();

    // Reset in the middle of a RUN after 5 retirements.
    do_reset();
    pc = 32'h100;
    cmd(2'd1, 16'd0);
    repeat (5) tick();
    check("pre_rst_cnt", instr_count, 32'd5);
    reset = 1'b1;
    #1;
    check("async_core_en", 32'(core_en), 32'd0);
    check("async_halted",  32'(halted), 32'd1);
    check("async_cnt",     instr_count, 32'd0);
    model_reset();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_halted", 32'(halted), 32'd1);

    // Long STEP, halted by command during the 100th retirement.
    pc = 32'd0; ce_seen = 0;
    cmd(2'd2, 16'hFFFF);
    k = 0;
    while (ce_seen < 99 && k < 300) begin tick(); k++; end
    check("long_timeout", 32'(k < 300), 32'd1);
    cmd(2'd0, 16'd0);
    tick();
    check("long_cause", 32'(halt_cause), 32'd1);
    check("long_cnt",   instr_count, 32'd100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
